psum_collector: RTL and testbench
=================================

Name: psum_collector

Overview:
- Receives the column-skewed partial-sum stream from the bottom row of the weight-stationary systolic array (`ARRAY_COL` columns x `ACC_WIDTH` bits).
- De-skews the columns and accumulates results across K-tiles into an M-entry buffer.
- After the last K-tile, drains the finished rows to downstream logic over a valid/ready stream.
- Sits between systolic_array.out_psum_vec and the requant/writeback stage.

Parameters:
- DEPTH, 64, maximum number of output rows (M) held in the accumulation buffer.
- KT_W, 16, width of the K-tile count configuration.
- Uses `ARRAY_COL` and `ACC_WIDTH` from params.vh. Derived value: MW = $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_*; accepted only in IDLE
- cfg_m_len  in  MW  number of rows per tile, legal range 1..DEPTH
- cfg_k_tiles  in  KT_W  number of K-tiles to accumulate, 1..2^KT_W-1
- in_psum_vec  in  `ARRAY_COL`*`ACC_WIDTH`  array bottom-row psums; column c is lane [c*ACC_WIDTH +: ACC_WIDTH]
- in_col0_valid  in  1  lane 0 holds valid psum for the next row; lane c holds that row's data c cycles later
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accept
- out_psum_vec  out  `ARRAY_COL`*`ACC_WIDTH`  accumulated row
- out_last  out  1  high with the final row (index m_len-1)
- busy  out  1  state != IDLE
- err_overrun  out  1  sticky; a sample was dropped

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is synchronous and active-low.
  - Reset values: out_valid=0, out_last=0, out_psum_vec=0, busy=0, err_overrun=0. All counters=0, state=IDLE, deskew registers=0, delayed-valid shift register=0.
  - Buffer contents are not reset (don't care).
- Deskew:
  - Lane c passes through (`ARRAY_COL`-1-c) register stages; lane `ARRAY_COL`-1 has zero stages.
  - aligned_valid is in_col0_valid delayed `ARRAY_COL`-1 cycles.
  - The deskew pipeline runs in every state, including while drain is stalled.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start with cfg_m_len in 1..DEPTH and cfg_k_tiles != 0 latches the config, clears row_idx and k_idx, and moves to ACCUM next cycle.
  - Otherwise start is ignored.
  - start outside IDLE is always ignored.
- ACCUM:
  - On each aligned_valid: if k_idx==0, buf[row_idx] <= aligned row; else buf[row_idx] <= buf[row_idx] + aligned row. The add is per lane, `ACC_WIDTH` two's-complement, wrap on overflow.
  - Buffer write completes in the same cycle; read is combinational.
  - row_idx increments. At row_idx==m_len-1 it wraps to 0 and k_idx increments.
  - When the sample completing k_idx==k_tiles-1 is written, move to DRAIN and set drain_idx=0.
- DRAIN:
  - Registered output: first out_valid is asserted the cycle after entering DRAIN.
  - out_psum_vec=buf[drain_idx]; out_last=(drain_idx==m_len-1).
  - On out_valid&&out_ready: advance drain_idx. If this was the last row, deassert out_valid next cycle and return to IDLE.
  - Without out_ready, out_valid/out_psum_vec/out_last hold stable.
- Drop rule: aligned_valid while in IDLE or DRAIN drops the sample and sets err_overrun. Only reset clears err_overrun.
- Mid-operation reset: all state returns to IDLE immediately, and in-flight deskew data is discarded.
- Latency:
  - in_col0_valid to buffer write: `ARRAY_COL`-1 cycles, plus 1 for the register write.
  - Final write to first out_valid: 2 cycles.

Optional Feature:
- Macro: PSUM_COLLECTOR_RELU_EN.
- Defined: on the drain output only, any negative lane is replaced by 0. Buffer contents are unchanged.
- Undefined: drain output is the raw accumulated value.

Decomposition:
- params.vh holds `ARRAY_COL`, `ACC_WIDTH`, and the new `PSUM_BUF_DEPTH` (the default for DEPTH).
- Encode state values as localparams inside the module.
- One natural sub-module: psum_deskew, the parameterised per-lane delay line plus the valid delay. It is reusable for the act-input skew.

Test Plan:
- Single tile: m_len=4, k_tiles=1; feed rows r with lane c = 100*r+c, skewed per lane -> four drained rows equal the inputs exactly; out_last only on row 3; busy low after the last handshake.
- K accumulation: m_len=2, k_tiles=3; every lane of every tile = 5, then -2, then 7 -> drained lanes = 10 in each row.
- Backpressure: out_ready low for 5 cycles mid-drain, then toggling -> no row lost or duplicated; data stable while stalled; order is rows 0..m_len-1.
- Boundaries: m_len=DEPTH=64 full buffer -> all rows correct. cfg_m_len=0 or cfg_k_tiles=0 -> start ignored, busy stays 0. Lane sum 0x7FFFFFFF+1 -> 0x80000000 (wrap).
- Overrun/reset: aligned sample arriving during DRAIN -> err_overrun=1 and buffer unchanged. rst_n low for one cycle mid-ACCUM -> IDLE, err_overrun=0, and a following start/tile produces correct results.
- With PSUM_COLLECTOR_RELU_EN defined: accumulated lane -3 -> output 0; lane 9 -> output 9.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - widths, row vector type and per-lane helpers for psum_collector
`include "params.vh"

package psum_collector_pkg;

  localparam int ARRAY_COL      = `ARRAY_COL;
  localparam int ACC_WIDTH      = `ACC_WIDTH;
  localparam int VEC_W          = ARRAY_COL * ACC_WIDTH;
  localparam int PSUM_BUF_DEPTH = `PSUM_BUF_DEPTH;

  typedef logic [VEC_W-1:0] psum_vec_t;

  // Lane-wise two's-complement add; each lane wraps independently.
  function automatic psum_vec_t vec_add(input psum_vec_t a, input psum_vec_t b);
    psum_vec_t s;
    s = '0;
    for (int c = 0; c < ARRAY_COL; c++) begin
      s[c*ACC_WIDTH +: ACC_WIDTH] = a[c*ACC_WIDTH +: ACC_WIDTH] + b[c*ACC_WIDTH +: ACC_WIDTH];
    end
    return s;
  endfunction

  function automatic psum_vec_t vec_relu(input psum_vec_t a);
    psum_vec_t r;
    r = a;
    for (int c = 0; c < ARRAY_COL; c++) begin
      if (a[c*ACC_WIDTH + ACC_WIDTH - 1]) r[c*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/params.vh
// rtl/params.vh - systolic array geometry shared by the array, collector and writeback blocks
`ifndef PARAMS_VH
`define PARAMS_VH

`define ARRAY_COL 4
`define ACC_WIDTH 32
`define PSUM_BUF_DEPTH 64

`endif

// File: rtl/psum_deskew.sv
// rtl/psum_deskew.sv - per-lane delay line undoing the systolic column skew, plus matching valid delay
module psum_deskew #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] in_vec,
  input  logic                    in_valid,
  output logic [LANES*LANE_W-1:0] out_vec,
  output logic                    out_valid
);

  // Lane c arrives c cycles after lane 0, so it needs LANES-1-c stages.
  for (genvar c = 0; c < LANES; c++) begin : g_lane
    localparam int D = LANES - 1 - c;
    if (D == 0) begin : g_pass
      assign out_vec[c*LANE_W +: LANE_W] = in_vec[c*LANE_W +: LANE_W];
    end else begin : g_dly
      logic [LANE_W-1:0] sr_q [D];
      logic [LANE_W-1:0] sr_d [D];

      always_comb begin
        sr_d[0] = in_vec[c*LANE_W +: LANE_W];
        for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < D; s++) sr_q[s] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign out_vec[c*LANE_W +: LANE_W] = sr_q[D-1];
    end
  end

  if (LANES == 1) begin : g_vld_pass
    assign out_valid = in_valid;
  end else begin : g_vld_dly
    logic [LANES-2:0] vld_q;
    logic [LANES-2:0] vld_d;

    always_comb vld_d = (vld_q << 1) | (LANES-1)'(in_valid);

    always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    assign out_valid = vld_q[LANES-2];
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - de-skews array psums, accumulates K-tiles per row, drains rows over valid/ready
// Optional PSUM_COLLECTOR_RELU_EN clamps negative lanes to zero on the drain output only.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int DEPTH = PSUM_BUF_DEPTH,
  parameter int KT_W  = 16,
  localparam int MW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MW-1:0]    cfg_m_len,
  input  logic [KT_W-1:0]  cfg_k_tiles,
  input  logic [VEC_W-1:0] in_psum_vec,
  input  logic             in_col0_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_psum_vec,
  output logic             out_last,
  output logic             busy,
  output logic             err_overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   m_last_q, m_last_d;
  logic [KT_W-1:0] k_last_q, k_last_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic [KT_W-1:0] k_idx_q, k_idx_d;
  logic [AW-1:0]   drain_idx_q, drain_idx_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  psum_vec_t       out_psum_q, out_psum_d;
  logic            err_q, err_d;

  psum_vec_t       mem_q [DEPTH];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  psum_vec_t       wr_data;

  psum_vec_t       aligned_vec;
  logic            aligned_valid;
  logic            cfg_ok;
  logic [AW-1:0]   drain_nxt;

  psum_deskew #(.LANES(ARRAY_COL), .LANE_W(ACC_WIDTH)) u_deskew (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_psum_vec),
    .in_valid  (in_col0_valid),
    .out_vec   (aligned_vec),
    .out_valid (aligned_valid)
  );

  function automatic psum_vec_t drain_view(input psum_vec_t v);
`ifdef PSUM_COLLECTOR_RELU_EN
    return vec_relu(v);
`else
    return v;
`endif
  endfunction

  assign cfg_ok    = (cfg_m_len != '0) && (cfg_m_len <= MW'(DEPTH)) && (cfg_k_tiles != '0);
  assign drain_nxt = drain_idx_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    m_last_d    = m_last_q;
    k_last_d    = k_last_q;
    row_idx_d   = row_idx_q;
    k_idx_d     = k_idx_q;
    drain_idx_d = drain_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_psum_d  = out_psum_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_addr     = row_idx_q;
    wr_data     = aligned_vec;

    case (state_q)
      S_IDLE: begin
        if (aligned_valid) err_d = 1'b1;
        if (start && cfg_ok) begin
          m_last_d  = AW'(cfg_m_len - MW'(1));
          k_last_d  = cfg_k_tiles - KT_W'(1);
          row_idx_d = '0;
          k_idx_d   = '0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (aligned_valid) begin
          wr_en   = 1'b1;
          wr_data = (k_idx_q == '0) ? aligned_vec : vec_add(mem_q[row_idx_q], aligned_vec);
          if (row_idx_q == m_last_q) begin
            row_idx_d = '0;
            if (k_idx_q == k_last_q) begin
              state_d     = S_DRAIN;
              drain_idx_d = '0;
            end else begin
              k_idx_d = k_idx_q + KT_W'(1);
            end
          end else begin
            row_idx_d = row_idx_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (aligned_valid) err_d = 1'b1;
        // First DRAIN cycle only loads the output register; afterwards advance on handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_psum_d  = drain_view(mem_q[drain_idx_q]);
          out_last_d  = (drain_idx_q == m_last_q);
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_IDLE;
          end else begin
            drain_idx_d = drain_nxt;
            out_psum_d  = drain_view(mem_q[drain_nxt]);
            out_last_d  = (drain_nxt == m_last_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_last_q    <= '0;
      k_last_q    <= '0;
      row_idx_q   <= '0;
      k_idx_q     <= '0;
      drain_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_psum_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_last_q    <= m_last_d;
      k_last_q    <= k_last_d;
      row_idx_q   <= row_idx_d;
      k_idx_q     <= k_idx_d;
      drain_idx_q <= drain_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_psum_q  <= out_psum_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_psum_vec = out_psum_q;
  assign busy         = (state_q != S_IDLE);
  assign err_overrun  = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - directed self-checking bench for psum_collector
module tb_psum_collector;
  import psum_collector_pkg::*;

  localparam int DEPTH = PSUM_BUF_DEPTH;
  localparam int KT_W  = 16;
  localparam int MW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [MW-1:0]    cfg_m_len = '0;
  logic [KT_W-1:0]  cfg_k_tiles = '0;
  logic [VEC_W-1:0] in_psum_vec = '0;
  logic             in_col0_valid = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VEC_W-1:0] out_psum_vec;
  logic             out_last;
  logic             busy;
  logic             err_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  psum_vec_t smp [256];
  psum_vec_t exp_row [DEPTH];

  psum_collector #(.DEPTH(DEPTH), .KT_W(KT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_m_len     (cfg_m_len),
    .cfg_k_tiles   (cfg_k_tiles),
    .in_psum_vec   (in_psum_vec),
    .in_col0_valid (in_col0_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_psum_vec  (out_psum_vec),
    .out_last      (out_last),
    .busy          (busy),
    .err_overrun   (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic psum_vec_t lane_fn(input int r, input int mult);
    psum_vec_t v;
    for (int c = 0; c < ARRAY_COL; c++) v[c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(mult * r + c);
    return v;
  endfunction

  function automatic psum_vec_t uniform(input logic [ACC_WIDTH-1:0] x);
    psum_vec_t v;
    for (int c = 0; c < ARRAY_COL; c++) v[c*ACC_WIDTH +: ACC_WIDTH] = x;
    return v;
  endfunction

  function automatic psum_vec_t exp_view(input psum_vec_t v);
    psum_vec_t r;
    r = v;
`ifdef PSUM_COLLECTOR_RELU_EN
    for (int c = 0; c < ARRAY_COL; c++) begin
      if (v[c*ACC_WIDTH + ACC_WIDTH - 1]) r[c*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
`endif
    return r;
  endfunction

  task automatic do_start(input int m, input int k);
    @(negedge clk);
    cfg_m_len   = MW'(m);
    cfg_k_tiles = KT_W'(k);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive n samples from smp[], skewing lane c by c cycles like the array bottom row.
  task automatic feed(input int n);
    for (int i = 0; i < n + ARRAY_COL - 1; i++) begin
      @(negedge clk);
      in_col0_valid = (i < n);
      for (int c = 0; c < ARRAY_COL; c++) begin
        int r;
        r = i - c;
        if (r >= 0 && r < n) in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH] = smp[r][c*ACC_WIDTH +: ACC_WIDTH];
        else                 in_psum_vec[c*ACC_WIDTH +: ACC_WIDTH] = '0;
      end
    end
    @(negedge clk);
    in_col0_valid = 1'b0;
    in_psum_vec   = '0;
  endtask

  // mode 0: always ready; mode 1: stall 5 cycles after the first row, then toggle.
  task automatic drain(input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    int stall = 0;
    logic held_valid = 1'b0;
    logic rdy;
    psum_vec_t held = '0;
    while (acc < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held_valid && out_valid) check("stall_hold", out_psum_vec, held);
      if (mode == 0 || acc == 0) rdy = 1'b1;
      else if (stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else rdy = cyc[0];
      out_ready = rdy;
      if (out_valid && rdy) begin
        check($sformatf("row%0d", acc), out_psum_vec, exp_row[acc]);
        check($sformatf("last%0d", acc), VEC_W'(out_last), VEC_W'(acc == n - 1));
        acc++;
        held_valid = 1'b0;
      end else begin
        held_valid = out_valid;
        held       = out_psum_vec;
      end
    end
    check("drain_count", VEC_W'(acc), VEC_W'(n));
    @(negedge clk);
    out_ready = 1'b0;
    check("busy_after_drain", VEC_W'(busy), VEC_W'(1'b0));
    check("valid_after_drain", VEC_W'(out_valid), VEC_W'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    psum_vec_t v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", VEC_W'(busy), VEC_W'(1'b0));
    check("rst_valid", VEC_W'(out_valid), VEC_W'(1'b0));
    check("rst_last", VEC_W'(out_last), VEC_W'(1'b0));
    check("rst_psum", out_psum_vec, '0);
    check("rst_err", VEC_W'(err_overrun), VEC_W'(1'b0));

    // Single tile, lane c of row r = 100r+c.
    for (int r = 0; r < 4; r++) begin
      smp[r]     = lane_fn(r, 100);
      exp_row[r] = exp_view(lane_fn(r, 100));
    end
    do_start(4, 1);
    check("busy_start", VEC_W'(busy), VEC_W'(1'b1));
    feed(4);
    drain(4, 0);

    // K accumulation: 5 + (-2) + 7 = 10 on every lane.
    for (int r = 0; r < 2; r++) begin
      smp[r]     = uniform(32'd5);
      smp[2 + r] = uniform(-32'sd2);
      smp[4 + r] = uniform(32'd7);
      exp_row[r] = exp_view(uniform(32'd10));
    end
    do_start(2, 3);
    feed(6);
    drain(2, 0);
    check("err_clean", VEC_W'(err_overrun), VEC_W'(1'b0));

    // Backpressure with stalls and toggling ready.
    for (int r = 0; r < 6; r++) begin
      smp[r]     = lane_fn(r, 1000);
      exp_row[r] = exp_view(lane_fn(r, 1000));
    end
    do_start(6, 1);
    feed(6);
    drain(6, 1);

    // Full buffer.
    for (int r = 0; r < DEPTH; r++) begin
      smp[r]     = lane_fn(r, 7);
      exp_row[r] = exp_view(lane_fn(r, 7));
    end
    do_start(DEPTH, 1);
    feed(DEPTH);
    drain(DEPTH, 0);

    // Illegal configurations are ignored.
    do_start(0, 1);
    check("ign_m0", VEC_W'(busy), VEC_W'(1'b0));
    do_start(4, 0);
    check("ign_k0", VEC_W'(busy), VEC_W'(1'b0));
    do_start(DEPTH + 1, 1);
    check("ign_mbig", VEC_W'(busy), VEC_W'(1'b0));

    // Lane wrap: 0x7FFFFFFF + 1.
    smp[0]     = uniform(32'h7FFF_FFFF);
    smp[1]     = uniform(32'h0000_0001);
    exp_row[0] = exp_view(uniform(32'h8000_0000));
    do_start(1, 2);
    feed(2);
    drain(1, 0);

    // Sign handling on the drain output (ReLU clamps -3 when enabled).
    v = uniform(32'd0);
    v[0 +: ACC_WIDTH]         = -32'sd3;
    v[ACC_WIDTH +: ACC_WIDTH] = 32'd9;
    smp[0]     = v;
    exp_row[0] = exp_view(v);
    do_start(1, 1);
    feed(1);
    drain(1, 0);

    // Third sample aligns during DRAIN: dropped, flagged, buffer intact.
    smp[0]     = uniform(32'd11);
    smp[1]     = uniform(32'd22);
    smp[2]     = uniform(32'd999);
    exp_row[0] = exp_view(uniform(32'd11));
    exp_row[1] = exp_view(uniform(32'd22));
    do_start(2, 1);
    feed(3);
    check("overrun_set", VEC_W'(err_overrun), VEC_W'(1'b1));
    drain(2, 0);
    check("overrun_sticky", VEC_W'(err_overrun), VEC_W'(1'b1));

    // Reset in the middle of ACCUM, then a clean two-tile run.
    smp[0] = uniform(32'd50);
    smp[1] = uniform(32'd60);
    do_start(4, 1);
    feed(2);
    check("busy_mid", VEC_W'(busy), VEC_W'(1'b1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", VEC_W'(busy), VEC_W'(1'b0));
    check("mrst_err", VEC_W'(err_overrun), VEC_W'(1'b0));
    check("mrst_valid", VEC_W'(out_valid), VEC_W'(1'b0));
    for (int r = 0; r < 3; r++) begin
      smp[r]     = lane_fn(r, 10);
      smp[3 + r] = uniform(32'd1);
      exp_row[r] = exp_view(lane_fn(r, 10) + uniform(32'd0) | '0);
      for (int c = 0; c < ARRAY_COL; c++) exp_row[r][c*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(10 * r + c + 1);
      exp_row[r] = exp_view(exp_row[r]);
    end
    do_start(3, 2);
    feed(6);
    drain(3, 0);
    check("final_err", VEC_W'(err_overrun), VEC_W'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
